imem_server: RTL and testbench

IMEM_SERVER -- requirements
Module: imem_server

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_loader.sv | 88 ++++++++
 rtl/imem_server.sv | 117 +++++++++++
 tb/tb_imem_server.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction memory server.
package imem_pkg;

  localparam logic [31:0] NOP_CMD       = 32'h0000_0013;
  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam logic [6:0]  OPCODE_SYSTEM = 7'b111_0011;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_loader.sv
// Assembles the little-endian loader byte stream into 32-bit words and owns
// the write pointer (words_loaded) into the instruction array.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          load_en,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          load_end,
  output logic [AW:0]   words_loaded
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  logic [1:0]  lane_r;
  logic [31:0] buf_r;
  logic [AW:0] count_r;
  logic        accept_s;
  logic        wr_s;
  logic        end_s;
  logic [31:0] word_s;

  // Merge the incoming byte into the partial word and decide write / end.
  always_comb begin
    accept_s = load_en & ld_valid;
    word_s   = buf_r;
    wr_s     = 1'b0;
    end_s    = 1'b0;
    if (accept_s) begin
      case (lane_r)
        2'd0:    word_s[7:0]   = ld_byte;
        2'd1:    word_s[15:8]  = ld_byte;
        2'd2:    word_s[23:16] = ld_byte;
        2'd3:    word_s[31:24] = ld_byte;
        default: word_s        = buf_r;
      endcase
    end else begin
      word_s = buf_r;
    end
    // A done strobe flushes whatever is pending, including this cycle's byte.
    if (count_r < FULL) begin
      wr_s = (accept_s && (lane_r == 2'd3)) ||
             (load_en && ld_done && (accept_s || (lane_r != 2'd0)));
    end else begin
      wr_s = 1'b0;
    end
    if (load_en) begin
      end_s = ld_done || (wr_s && (count_r == LAST));
    end else begin
      end_s = 1'b0;
    end
  end

  // Lane counter, partial word buffer and write pointer.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      lane_r  <= 2'd0;
      buf_r   <= 32'h0000_0000;
      count_r <= '0;
    end else if (wr_s) begin
      lane_r  <= 2'd0;
      buf_r   <= 32'h0000_0000;
      count_r <= count_r + (AW+1)'(1);
    end else if (accept_s) begin
      lane_r  <= lane_r + 2'd1;
      buf_r   <= word_s;
    end else begin
      lane_r  <= lane_r;
      buf_r   <= buf_r;
      count_r <= count_r;
    end
  end

  assign wr_en        = wr_s;
  assign wr_addr      = count_r[AW-1:0];
  assign wr_data      = word_s;
  assign load_end     = end_s;
  assign words_loaded = count_r;

endmodule

// File: rtl/imem_server.sv
// Instruction memory: filled once by a byte loader, then serves zero-latency
// fetches and flags any bad fetch with a sticky fault.
module imem_server
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = RESET_PC
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     imem_req,
  input  logic [31:0]              imem_addr,
  output logic [31:0]              imem_data,
  output logic                     imem_fault,
  input  logic                     ld_valid,
  input  logic [7:0]               ld_byte,
  output logic                     ld_ready,
  input  logic                     ld_done,
  output logic                     run,
  output logic [$clog2(DEPTH):0]   words_loaded
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  imem_state_t   state_r;
  imem_state_t   state_nxt_s;
  logic          fault_r;
  logic [31:0]   mem_r [DEPTH];
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [31:0]   wr_data_s;
  logic          load_end_s;
  logic [AW:0]   words_s;
  logic [32:0]   diff_s;
  logic [AW-1:0] idx_s;
  logic          valid_s;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) u_loader (
    .clk          (clk),
    .res_n        (res_n),
    .load_en      (state_r == LOAD),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_done      (ld_done),
    .wr_en        (wr_en_s),
    .wr_addr      (wr_addr_s),
    .wr_data      (wr_data_s),
    .load_end     (load_end_s),
    .words_loaded (words_s)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD: begin
        if (load_end_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = LOAD;
    endcase
  end

  // Array contents are deliberately not reset; words_loaded gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // The 33-bit subtraction exposes a borrow so addresses below the base never wrap.
  always_comb begin
    diff_s    = {1'b0, imem_addr} - {1'b0, BASE_ADDR};
    idx_s     = diff_s[AW+1:2];
    valid_s   = 1'b0;
    imem_data = NOP_CMD;
    if (!diff_s[32] && (diff_s[31:0] < SPAN) && (diff_s[1:0] == 2'b00) &&
        ({1'b0, idx_s} < words_s)) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    if ((state_r == RUN) && valid_s) begin
      imem_data = mem_r[idx_s];
    end else begin
      imem_data = NOP_CMD;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      fault_r <= 1'b0;
    end else if ((state_r == RUN) && imem_req && !valid_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign imem_fault   = fault_r;
  assign run          = (state_r == RUN);
  assign ld_ready     = (state_r == LOAD);
  assign words_loaded = words_s;

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server: loader sequences plus a table of RUN fetches.
module tb_imem_server;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        res_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_fault;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_done;
  logic        run;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic [31:0] data;
    logic        fault;
  } vec_t;

  vec_t vt [8];

  imem_server #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .res_n        (res_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_fault   (imem_fault),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_ready     (ld_ready),
    .ld_done      (ld_done),
    .run          (run),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_done  = d;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    repeat (2) tick();
    res_n = 1'b1;
    tick();
  endtask

  task automatic fetch(input string nm, input logic [31:0] a, input logic r,
                       input logic [31:0] d, input logic f);
    imem_addr = a;
    imem_req  = r;
    #1;
    chk({nm, "_data"}, imem_data, d);
    tick();
    chk({nm, "_fault"}, {31'd0, imem_fault}, {31'd0, f});
  endtask

  initial begin
    vt[0] = '{32'h0000_0000, 1'b1, 32'h0050_0013, 1'b0};
    vt[1] = '{32'h0000_0004, 1'b1, 32'h0000_00B3, 1'b0};
    vt[2] = '{32'h0000_0002, 1'b0, NOP,           1'b0};
    vt[3] = '{32'h0000_0008, 1'b0, NOP,           1'b0};
    vt[4] = '{32'hFFFF_FFFC, 1'b0, NOP,           1'b0};
    vt[5] = '{32'h0000_0400, 1'b0, NOP,           1'b0};
    vt[6] = '{32'h0000_0008, 1'b1, NOP,           1'b1};
    vt[7] = '{32'h0000_0004, 1'b1, 32'h0000_00B3, 1'b1};

    res_n = 1'b0; imem_req = 1'b0; imem_addr = 32'h0;
    ld_valid = 1'b0; ld_byte = 8'h00; ld_done = 1'b0;
    do_reset();

    // Reset state
    chk("rst_run",   {31'd0, run},      32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_words", {23'd0, words_loaded}, 32'd0);
    chk("rst_fault", {31'd0, imem_fault}, 32'd0);
    chk("rst_data",  imem_data, NOP);

    // Two-word image, done strobe on its own cycle
    send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h50, 1'b0); send(8'h00, 1'b0);
    send(8'hB3, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    chk("img1_words_pre", {23'd0, words_loaded}, 32'd2);
    chk("img1_run_pre",   {31'd0, run}, 32'd0);
    chk("img1_load_nop",  imem_data, NOP);
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    chk("img1_run",   {31'd0, run},      32'd1);
    chk("img1_ready", {31'd0, ld_ready}, 32'd0);
    chk("img1_words", {23'd0, words_loaded}, 32'd2);
    send(8'hFF, 1'b1);
    chk("img1_ignore", {23'd0, words_loaded}, 32'd2);

    for (int i = 0; i < 8; i++) begin
      fetch($sformatf("vec%0d", i), vt[i].addr, vt[i].req, vt[i].data, vt[i].fault);
    end
    imem_req = 1'b0;
    repeat (10) tick();
    chk("fault_sticky", {31'd0, imem_fault}, 32'd1);

    // Partial word with done on the second byte; misaligned fetch faults
    do_reset();
    chk("r2_fault_clr", {31'd0, imem_fault}, 32'd0);
    send(8'h93, 1'b0); send(8'h00, 1'b1);
    chk("r2_words", {23'd0, words_loaded}, 32'd1);
    chk("r2_run",   {31'd0, run}, 32'd1);
    fetch("r2_w0",    32'h0000_0000, 1'b0, 32'h0000_0093, 1'b0);
    fetch("r2_w1",    32'h0000_0004, 1'b0, NOP,           1'b0);
    fetch("r2_mis0",  32'h0000_0002, 1'b0, NOP,           1'b0);
    fetch("r2_mis1",  32'h0000_0002, 1'b1, NOP,           1'b1);

    // Reset mid-load discards the partial word
    do_reset();
    for (int i = 0; i < 6; i++) send(8'(8'h11 + i), 1'b0);
    chk("r3_words_mid", {23'd0, words_loaded}, 32'd1);
    #2 res_n = 1'b0;
    #1;
    chk("r3_words_rst", {23'd0, words_loaded}, 32'd0);
    chk("r3_ready_rst", {31'd0, ld_ready}, 32'd1);
    chk("r3_run_rst",   {31'd0, run}, 32'd0);
    tick(); res_n = 1'b1; tick();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    chk("r3_words", {23'd0, words_loaded}, 32'd1);
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    fetch("r3_w0", 32'h0000_0000, 1'b1, 32'hDDCC_BBAA, 1'b0);

    // Full array without done: auto-RUN, no wrap
    do_reset();
    for (int i = 0; i < 1023; i++) send(8'(i), 1'b0);
    chk("full_run_pre",   {31'd0, run}, 32'd0);
    chk("full_words_pre", {23'd0, words_loaded}, 32'd255);
    send(8'hFF, 1'b0);
    chk("full_run",   {31'd0, run}, 32'd1);
    chk("full_words", {23'd0, words_loaded}, 32'd256);
    chk("full_ready", {31'd0, ld_ready}, 32'd0);
    send(8'h55, 1'b1);
    chk("full_words_post", {23'd0, words_loaded}, 32'd256);
    fetch("full_w0",   32'h0000_0000, 1'b1, 32'h0302_0100, 1'b0);
    fetch("full_w255", 32'h0000_03FC, 1'b1, 32'hFFFE_FDFC, 1'b0);
    fetch("full_oob",  32'h0000_0400, 1'b1, NOP,           1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
